// File: rtl/mult_pkg.sv
// Shared types and widths for the shared-multiplier controller.
package mult_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/multiplier4bit.sv
// 4x4 unsigned array multiplier: sum of the AND-gated, shifted partial products.
module multiplier4bit
    import mult_pkg::*;
(
    input  logic [OPW-1:0] i_a,
    input  logic [OPW-1:0] i_b,
    output logic [PW-1:0]  o_p
);

    logic [PW-1:0] w_sum;

    // Accumulate one partial-product row per multiplier bit.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < OPW; i++) begin
            if (i_b[i]) begin
                w_sum = w_sum + (PW'(i_a) << i);
            end
        end
    end

    assign o_p = w_sum;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    logic [IDW-1:0] w_cand;

    // NREQ is a power of two, so the IDW-bit add wraps modulo NREQ for free.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = i_ptr + IDW'(k);
            if (i_en && !o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one 4x4 multiplier among NREQ requesters with round-robin grant and
// a valid/ready response channel.
//
// state | meaning
// IDLE  | arbitrate; grant and capture operands of the winner
// CALC  | register multiplier output
// RESP  | hold response until rsp_ready
module mult_share_ctrl
    import mult_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_product,
    input  logic              rsp_ready,
    output logic              busy
);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [OPW-1:0]  r_op_a;
    logic [OPW-1:0]  r_op_b;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [PW-1:0]   r_rsp_product;
    logic            r_busy;

    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gidx;
    logic            w_gany;
    logic [OPW-1:0]  w_sel_a;
    logic [OPW-1:0]  w_sel_b;
    logic [PW-1:0]   w_prod;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .i_en  (r_state == IDLE),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_gany)
    );

    multiplier4bit u_mult (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_p (w_prod)
    );

    // Operand mux selecting the winning requester's slices.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) begin
                w_sel_a = req_a[i*OPW +: OPW];
                w_sel_b = req_b[i*OPW +: OPW];
            end
        end
    end

    // Control FSM with operand, pointer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_product <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gany) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_rsp_id <= w_gidx;
                        r_ptr    <= w_gidx + 1'b1;
                        r_state  <= CALC;
                        r_busy   <= 1'b1;
                    end
                end
                CALC: begin
                    r_rsp_product <= w_prod;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_product = r_rsp_product;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with NREQ=4.
module tb_mult_share_ctrl;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_product;
    logic        rsp_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_ctrl #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset and idle
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_product", 32'(rsp_product), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        check("idle_busy", 32'(busy), 0);
        check("idle_req_ready", 32'(req_ready), 0);

        // Single request, max operands
        req_valid = 4'b0100;
        set_op(2, 4'd15, 4'd15);
        #1;
        check("single_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        #1;
        check("calc_req_ready", 32'(req_ready), 0);
        check("calc_busy", 32'(busy), 1);
        check("calc_rsp_valid", 32'(rsp_valid), 0);
        step();
        check("single_rsp_valid", 32'(rsp_valid), 1);
        check("single_rsp_id", 32'(rsp_id), 2);
        check("single_rsp_product", 32'(rsp_product), 32'hE1);

        // Back-pressure: hold response 5 cycles with a pending request
        req_valid = 4'b0001;
        set_op(0, 4'd4, 4'd6);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req_ready", 32'(req_ready), 0);
            check("stall_rsp_valid", 32'(rsp_valid), 1);
            check("stall_rsp_id", 32'(rsp_id), 2);
            check("stall_rsp_product", 32'(rsp_product), 32'hE1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(req_ready), 0);
        step();
        #1;
        check("post_hs_rsp_valid", 32'(rsp_valid), 0);
        check("post_hs_grant_wrap", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        check("wrap_rsp_id", 32'(rsp_id), 0);
        check("wrap_rsp_product", 32'(rsp_product), 32'd24);
        step();
        rsp_ready = 1'b0;

        // Round robin from reset, all requesters held valid
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd3);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int g = 0; g < 8; g++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            step();
            check("rr_calc_ready", 32'(req_ready), 0);
            step();
            check("rr_rsp_valid", 32'(rsp_valid), 1);
            check("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
            check("rr_rsp_product", 32'(rsp_product), 32'((g % 4 + 1) * 3));
            step();
        end

        // Reset during CALC abandons the op and clears the pointer
        req_valid = 4'b0100;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b1010;
        set_op(1, 4'd7, 4'd9);
        set_op(3, 4'd5, 4'd5);
        rst = 1'b1;
        #1;
        check("rst_calc_ready", 32'(req_ready), 0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_rsp_valid", 32'(rsp_valid), 0);
        check("after_rst_busy", 32'(busy), 0);
        check("after_rst_grant", 32'(req_ready), 32'h2);
        step();
        step();
        check("after_rst_rsp_id", 32'(rsp_id), 1);
        check("after_rst_product", 32'(rsp_product), 32'h3F);
        step();
        #1;
        check("next_grant_3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        check("next_rsp_id", 32'(rsp_id), 3);
        check("next_rsp_product", 32'(rsp_product), 32'd25);
        step();
        rsp_ready = 1'b0;

        // Exhaustive operands through requester 0, random rsp_ready
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req_valid = 4'b0001;
                set_op(0, 4'(a), 4'(b));
                #1;
                check("ex_grant", 32'(req_ready), 32'h1);
                step();
                req_valid = '0;
                step();
                for (int w = 0; w < 8; w++) begin
                    rsp_ready = (w == 7) ? 1'b1 : 1'($urandom_range(0, 1));
                    #1;
                    check("ex_rsp_valid", 32'(rsp_valid), 1);
                    check("ex_rsp_product", 32'(rsp_product), 32'(a * b));
                    check("ex_rsp_id", 32'(rsp_id), 0);
                    step();
                    if (rsp_ready) break;
                end
                rsp_ready = 1'b0;
            end
        end
        #1;
        check("final_idle_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
